// File: rtl/pixel_stream_source.sv
// Raster stream transmitter: pulls pixels over ready/valid and emits one frame of LINES lines,
// each ACTIVE_W active pixels followed by BLANK_W blanking beats, on the window's din/blanking/valid.
module pixel_stream_source #(
  parameter int DATA_W   = 8,
  parameter int ACTIVE_W = 398,
  parameter int BLANK_W  = 2,
  parameter int LINES    = 336,
  parameter int STALL_W  = 16
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic [DATA_W-1:0]  pix_data,
  input  logic               pix_valid,
  output logic               pix_ready,
  output logic [DATA_W-1:0]  dout,
  output logic               blanking_out,
  output logic               validout,
  output logic               busy,
  output logic               frame_done,
  output logic [STALL_W-1:0] stall_count
);

  localparam int COL_W    = (ACTIVE_W > 1) ? $clog2(ACTIVE_W) : 1;
  localparam int LINE_W   = (LINES > 1) ? $clog2(LINES) : 1;
  localparam int BLANK_CW = (BLANK_W > 1) ? $clog2(BLANK_W) : 1;

  localparam logic [COL_W-1:0]    COL_LAST   = COL_W'(ACTIVE_W - 1);
  localparam logic [LINE_W-1:0]   LINE_LAST  = LINE_W'(LINES - 1);
  localparam logic [BLANK_CW-1:0] BLANK_LAST = BLANK_CW'(BLANK_W - 1);
  localparam logic [COL_W-1:0]    COL_ZERO   = {COL_W{1'b0}};
  localparam logic [LINE_W-1:0]   LINE_ZERO  = {LINE_W{1'b0}};
  localparam logic [BLANK_CW-1:0] BLANK_ZERO = {BLANK_CW{1'b0}};
  localparam logic [DATA_W-1:0]   DATA_ZERO  = {DATA_W{1'b0}};
  localparam logic [STALL_W-1:0]  STALL_ZERO = {STALL_W{1'b0}};
  localparam logic [STALL_W-1:0]  STALL_MAX  = {STALL_W{1'b1}};

  // S_DONE is the cycle in which the final blanking beat sits on the outputs.
  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACTIVE = 2'd1,
    S_BLANK  = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [COL_W-1:0]     r_col;
  logic [LINE_W-1:0]    r_line;
  logic [BLANK_CW-1:0]  r_blank;
  logic [STALL_W-1:0]   r_stall_count;
  logic [DATA_W-1:0]    r_dout;
  logic                 r_validout;
  logic                 r_blanking;
  logic                 r_busy;
  logic                 r_frame_done;

  logic [COL_W-1:0]     w_col_nxt;
  logic [LINE_W-1:0]    w_line_nxt;
  logic [BLANK_CW-1:0]  w_blank_nxt;
  logic [STALL_W-1:0]   w_stall_nxt;
  logic [DATA_W-1:0]    w_dout_nxt;
  logic                 w_valid_nxt;
  logic                 w_blanking_nxt;
  logic                 w_busy_nxt;
  logic                 w_done_nxt;

  logic                 w_col_last;
  logic                 w_line_last;
  logic                 w_blank_last;

  assign w_col_last   = (r_col == COL_LAST);
  assign w_line_last  = (r_line == LINE_LAST);
  assign w_blank_last = (r_blank == BLANK_LAST);

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state decode; pix_valid only matters while pixels are being pulled.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_nxt = S_ACTIVE;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_ACTIVE: begin
        if (pix_valid && w_col_last) begin
          w_state_nxt = S_BLANK;
        end else begin
          w_state_nxt = S_ACTIVE;
        end
      end
      S_BLANK: begin
        if (!w_blank_last) begin
          w_state_nxt = S_BLANK;
        end else if (w_line_last) begin
          w_state_nxt = S_DONE;
        end else begin
          w_state_nxt = S_ACTIVE;
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Output and counter update for the next cycle.
  always_comb begin
    w_col_nxt      = r_col;
    w_line_nxt     = r_line;
    w_blank_nxt    = r_blank;
    w_stall_nxt    = r_stall_count;
    w_dout_nxt     = r_dout;
    w_valid_nxt    = 1'b0;
    w_blanking_nxt = 1'b0;
    w_busy_nxt     = r_busy;
    w_done_nxt     = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_dout_nxt = DATA_ZERO;
        if (start) begin
          w_col_nxt   = COL_ZERO;
          w_line_nxt  = LINE_ZERO;
          w_blank_nxt = BLANK_ZERO;
          w_stall_nxt = STALL_ZERO;
          w_busy_nxt  = 1'b1;
        end else begin
          w_busy_nxt  = 1'b0;
        end
      end
      S_ACTIVE: begin
        if (pix_valid) begin
          w_dout_nxt  = pix_data;
          w_valid_nxt = 1'b1;
          if (w_col_last) begin
            w_col_nxt   = COL_ZERO;
            w_blank_nxt = BLANK_ZERO;
          end else begin
            w_col_nxt   = r_col + COL_W'(1);
          end
        end else if (r_stall_count != STALL_MAX) begin
          w_stall_nxt = r_stall_count + STALL_W'(1);
        end else begin
          w_stall_nxt = r_stall_count;
        end
      end
      S_BLANK: begin
        w_dout_nxt     = DATA_ZERO;
        w_valid_nxt    = 1'b1;
        w_blanking_nxt = 1'b1;
        if (w_blank_last) begin
          w_blank_nxt = BLANK_ZERO;
          if (w_line_last) begin
            w_line_nxt = LINE_ZERO;
          end else begin
            w_line_nxt = r_line + LINE_W'(1);
          end
        end else begin
          w_blank_nxt = r_blank + BLANK_CW'(1);
        end
      end
      S_DONE: begin
        w_dout_nxt = DATA_ZERO;
        w_busy_nxt = 1'b0;
        w_done_nxt = 1'b1;
      end
      default: begin
        w_dout_nxt = DATA_ZERO;
        w_busy_nxt = 1'b0;
      end
    endcase
  end

  // Datapath and output registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_col         <= COL_ZERO;
      r_line        <= LINE_ZERO;
      r_blank       <= BLANK_ZERO;
      r_stall_count <= STALL_ZERO;
      r_dout        <= DATA_ZERO;
      r_validout    <= 1'b0;
      r_blanking    <= 1'b0;
      r_busy        <= 1'b0;
      r_frame_done  <= 1'b0;
    end else begin
      r_col         <= w_col_nxt;
      r_line        <= w_line_nxt;
      r_blank       <= w_blank_nxt;
      r_stall_count <= w_stall_nxt;
      r_dout        <= w_dout_nxt;
      r_validout    <= w_valid_nxt;
      r_blanking    <= w_blanking_nxt;
      r_busy        <= w_busy_nxt;
      r_frame_done  <= w_done_nxt;
    end
  end

  assign pix_ready    = (r_state == S_ACTIVE);
  assign dout         = r_dout;
  assign validout     = r_validout;
  assign blanking_out = r_blanking;
  assign busy         = r_busy;
  assign frame_done   = r_frame_done;
  assign stall_count  = r_stall_count;

endmodule

// File: tb/tb_pixel_stream_source.sv
// Self-checking bench for pixel_stream_source on a 4x3 frame with 2 blanking beats per line.
module tb_pixel_stream_source;

  localparam int DW    = 8;
  localparam int AW    = 4;
  localparam int BW    = 2;
  localparam int LN    = 3;
  localparam int SW    = 4;
  localparam int LL    = AW + BW;
  localparam int N     = LN * LL;
  localparam int NPIX  = AW * LN;
  localparam int SMAX  = (1 << SW) - 1;
  localparam int TBL_N = N + 4;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic          pix_valid = 1'b0;
  logic [DW-1:0] pix_data = 8'h00;
  logic          pix_ready;
  logic [DW-1:0] dout;
  logic          blanking_out;
  logic          validout;
  logic          busy;
  logic          frame_done;
  logic [SW-1:0] stall_count;

  int checks = 0;
  int errors = 0;
  logic [DW-1:0] pix_mem [0:NPIX-1];

  typedef struct {
    logic          start;
    logic          pv;
    logic [DW-1:0] pd;
    logic          e_valid;
    logic          e_blank;
    logic [DW-1:0] e_dout;
    logic          e_ready;
    logic          e_busy;
    logic          e_done;
  } vec_t;
  vec_t tbl [0:TBL_N-1];

  pixel_stream_source #(
    .DATA_W(DW), .ACTIVE_W(AW), .BLANK_W(BW), .LINES(LN), .STALL_W(SW)
  ) dut (
    .clock(clock), .reset(reset), .start(start),
    .pix_data(pix_data), .pix_valid(pix_valid), .pix_ready(pix_ready),
    .dout(dout), .blanking_out(blanking_out), .validout(validout),
    .busy(busy), .frame_done(frame_done), .stall_count(stall_count)
  );

  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("FAIL watchdog expired before summary");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // One frame: stimulus policy chosen by mode, expectations from a line/blank schedule model.
  task automatic run_frame(input int mode);
    int taken, blank_left, s, n_beats, c_end, inj, k, pos, ln, exp_s;
    bit in_frame, act, ended, pv, extra_start;
    logic [DW-1:0] last_dout, e_dout;
    for (int i = 0; i < NPIX; i++) pix_mem[i] = DW'($urandom);
    taken = 0; blank_left = 0; s = 0; n_beats = 0; c_end = -1; inj = 0;
    in_frame = 1'b1; ended = 1'b0; extra_start = 1'b0; last_dout = 8'h00;
    start = 1'b1;
    pix_valid = 1'b0;
    @(negedge clock);
    start = 1'b0;
    for (k = 0; k < 400; k++) begin
      act = in_frame && (blank_left == 0) && (taken < NPIX);
      chk("pix_ready", 32'(pix_ready), 32'(act));
      chk("busy", 32'(busy), 32'(!(ended && k > c_end)));
      chk("frame_done", 32'(frame_done), 32'(ended && k == c_end + 1));
      if (validout === 1'b1) begin
        chk("beat_in_range", 32'(n_beats < N), 32'd1);
        pos = n_beats % LL;
        ln  = n_beats / LL;
        e_dout = (pos >= AW || ln >= LN) ? 8'h00 : pix_mem[ln * AW + pos];
        chk("blanking", 32'(blanking_out), 32'(pos >= AW));
        chk("dout", 32'(dout), 32'(e_dout));
        last_dout = e_dout;
        n_beats++;
      end else begin
        chk("gap_blanking", 32'(blanking_out), 32'd0);
        chk("gap_dout_hold", 32'(dout), 32'(last_dout));
      end
      if (ended && k == c_end + 1) begin
        exp_s = (s > SMAX) ? SMAX : s;
        chk("frame_beats", 32'(n_beats), 32'(N));
        chk("stall_count", 32'(stall_count), 32'(exp_s));
        if (mode == 1) chk("stall_count_3", 32'(stall_count), 32'd3);
        if (mode == 5) chk("stall_count_sat", 32'(stall_count), 32'(SMAX));
      end
      if (ended && k >= c_end + 6) break;
      case (mode)
        1:       pv = !(taken == AW + 2 && inj < 3);
        2:       pv = (blank_left == 0);
        3:       pv = ($urandom_range(0, 3) != 0);
        5:       pv = !(taken == 1 && inj < 20);
        default: pv = 1'b1;
      endcase
      if ((mode == 1 || mode == 5) && !pv) inj++;
      start = (mode == 4) && !extra_start && act && (taken == 2 * AW + 1);
      if (start) extra_start = 1'b1;
      pix_valid = pv;
      pix_data  = (pv && taken < NPIX) ? pix_mem[taken] : DW'($urandom);
      if (act) begin
        if (pv) begin
          taken++;
          if (taken % AW == 0) blank_left = BW;
        end else begin
          s++;
        end
      end else if (in_frame && blank_left > 0) begin
        blank_left--;
        if (blank_left == 0 && taken == NPIX) begin
          in_frame = 1'b0;
          ended    = 1'b1;
          c_end    = k + 1;
        end
      end
      @(negedge clock);
    end
    chk("frame_completed", 32'(ended), 32'd1);
    start = 1'b0;
    pix_valid = 1'b0;
  endtask

  initial begin
    int p, idx;
    for (int n = 0; n < TBL_N; n++) begin
      p   = n - 1;
      idx = (p < 0) ? 0 : (p / LL) * AW + (((p % LL) < AW) ? (p % LL) : AW);
      tbl[n].start   = (n == 0);
      tbl[n].pv      = 1'b1;
      tbl[n].pd      = 8'h10 + DW'(idx);
      tbl[n].e_valid = (n >= 1) && (n <= N);
      tbl[n].e_blank = tbl[n].e_valid && ((p % LL) >= AW);
      tbl[n].e_dout  = (tbl[n].e_valid && !tbl[n].e_blank) ? 8'h10 + DW'(idx) : 8'h00;
      tbl[n].e_ready = (n < N) && ((n % LL) < AW);
      tbl[n].e_busy  = (n <= N);
      tbl[n].e_done  = (n == N + 1);
    end

    repeat (2) @(negedge clock);
    chk("rst_validout", 32'(validout), 32'd0);
    chk("rst_blanking", 32'(blanking_out), 32'd0);
    chk("rst_dout", 32'(dout), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_frame_done", 32'(frame_done), 32'd0);
    chk("rst_stall_count", 32'(stall_count), 32'd0);
    chk("rst_pix_ready", 32'(pix_ready), 32'd0);
    reset = 1'b0;
    @(negedge clock);

    for (int n = 0; n < TBL_N; n++) begin
      start     = tbl[n].start;
      pix_valid = tbl[n].pv;
      pix_data  = tbl[n].pd;
      @(negedge clock);
      chk("tbl_validout", 32'(validout), 32'(tbl[n].e_valid));
      chk("tbl_blanking", 32'(blanking_out), 32'(tbl[n].e_blank));
      chk("tbl_dout", 32'(dout), 32'(tbl[n].e_dout));
      chk("tbl_pix_ready", 32'(pix_ready), 32'(tbl[n].e_ready));
      chk("tbl_busy", 32'(busy), 32'(tbl[n].e_busy));
      chk("tbl_frame_done", 32'(frame_done), 32'(tbl[n].e_done));
      chk("tbl_stall_count", 32'(stall_count), 32'd0);
    end
    start = 1'b0;
    pix_valid = 1'b0;
    repeat (2) @(negedge clock);

    run_frame(1);
    run_frame(2);
    run_frame(4);

    // Asynchronous reset part-way through line 1, after one stall cycle.
    start = 1'b1;
    pix_valid = 1'b1;
    pix_data = 8'h55;
    @(negedge clock);
    start = 1'b0;
    repeat (LL + 2) @(negedge clock);
    pix_valid = 1'b0;
    @(negedge clock);
    pix_valid = 1'b1;
    @(negedge clock);
    chk("pre_reset_busy", 32'(busy), 32'd1);
    chk("pre_reset_validout", 32'(validout), 32'd1);
    chk("pre_reset_stall", 32'(stall_count), 32'd1);
    @(posedge clock);
    #2;
    reset = 1'b1;
    #1;
    chk("arst_validout", 32'(validout), 32'd0);
    chk("arst_dout", 32'(dout), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_stall", 32'(stall_count), 32'd0);
    chk("arst_pix_ready", 32'(pix_ready), 32'd0);
    chk("arst_blanking", 32'(blanking_out), 32'd0);
    @(negedge clock);
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      chk("post_rst_validout", 32'(validout), 32'd0);
      chk("post_rst_busy", 32'(busy), 32'd0);
      chk("post_rst_pix_ready", 32'(pix_ready), 32'd0);
    end
    pix_valid = 1'b0;
    run_frame(0);
    run_frame(5);
    for (int r = 0; r < 6; r++) run_frame(3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pixel_stream_source.md
Name: pixel_stream_source

Overview:
- Raster stream transmitter that drives the pixel-stream interface consumed by five_by_five_window: din/blanking_in/validin.
- Pulls pixels from an upstream ready/valid source (FIFO or memory reader).
- Emits one frame of LINES lines. Each line is ACTIVE_W active pixels followed by BLANK_W blanking beats.
- Sits between the frame-buffer read side and the filter pipeline. Guarantees the window sees a correctly formed line structure.

Parameters:
- DATA_W, 8: pixel width.
- ACTIVE_W, 398: active pixels per line.
- BLANK_W, 2: blanking beats per line (≥1).
- LINES, 336: lines per frame.
- STALL_W, 16: width of the stall counter.

Ports:
- clock  in  1  system clock; all logic on rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse; begins a frame when idle.
- pix_data  in  DATA_W  upstream pixel.
- pix_valid  in  1  upstream pixel available.
- pix_ready  out  1  block accepts pix_data this cycle.
- dout  out  DATA_W  pixel to window din.
- blanking_out  out  1  to window blanking_in.
- validout  out  1  to window validin.
- busy  out  1  frame in progress.
- frame_done  out  1  one-cycle pulse at end of frame.
- stall_count  out  STALL_W  active-phase cycles lost to upstream underflow in the current/last frame.

Behaviour:
- Reset (async, reset=1): state=IDLE; col, line, blank counters = 0.
  - Outputs: dout=0, blanking_out=0, validout=0, busy=0, frame_done=0, stall_count=0, pix_ready=0.
  - Deassertion mid-frame abandons the frame; no resume.
- States:
  - IDLE: on start=1 → ACTIVE; col=0, line=0, stall_count cleared, busy=1 from next cycle.
  - ACTIVE: pix_ready=1 (combinational, = state==ACTIVE).
    - Transfer when pix_valid & pix_ready.
    - Next cycle (registered, latency 1): dout=pix_data, validout=1, blanking_out=0; col++.
    - Transfer with col==ACTIVE_W-1 → BLANK; blank counter=0.
  - ACTIVE with pix_valid=0: underflow stall.
    - Next cycle validout=0, blanking_out=0, dout holds its last value.
    - col/line hold; stall_count++ (saturates at all-ones).
  - BLANK: pix_ready=0; each cycle emits validout=1, blanking_out=1, dout=0.
    - Never stalls; pix_valid ignored.
    - After BLANK_W beats: if line==LINES-1 → IDLE, else line++, col=0 → ACTIVE.
  - Exit from BLANK to IDLE: busy=0 and frame_done=1 in the cycle after the last blanking beat is presented. frame_done is high for exactly 1 cycle.
- Outputs are held in IDLE: validout=0, blanking_out=0, dout=0.
- start while busy=1 is ignored (no queuing).
- start in the same cycle as the frame_done transition is ignored; start must arrive while state=IDLE.
- Throughput: with pix_valid held high, a line occupies exactly ACTIVE_W+BLANK_W cycles with validout continuously 1. A frame is LINES*(ACTIVE_W+BLANK_W) valid beats, with no bubble between lines.
- The upstream handshake is never dropped: pix_data is sampled only on a transfer cycle. A pixel not accepted (pix_ready=0) must be held by upstream.
- Counter widths: col ≥ clog2(ACTIVE_W), line ≥ clog2(LINES), blank ≥ clog2(BLANK_W).
- No combinational path from pix_valid to any output except pix_ready, which does not depend on pix_valid.

Test Plan:
1. Small frame, no stalls. ACTIVE_W=4, BLANK_W=2, LINES=3; pix_valid=1, pix_data=0x10,0x11,…; start pulse.
   - 18 consecutive validout=1 beats beginning 1 cycle after the first transfer.
   - blanking_out=1 on beats 5,6,11,12,17,18 with dout=0 there.
   - dout=0x10..0x13, 0x14..0x17, 0x18..0x1B on the active beats.
   - frame_done one cycle after beat 18; busy=0 afterwards; stall_count=0.
2. Underflow stall. Same config; drop pix_valid for 3 cycles after the 2nd pixel of line 1.
   - validout=0 for exactly 3 cycles, then stream resumes with the 3rd pixel.
   - Blanking positions unchanged relative to active pixels; stall_count=3 at frame_done.
3. Stall never inside blanking. pix_valid=0 during every BLANK beat.
   - Blanking beats still emitted back-to-back with validout=1; pix_ready=0 throughout BLANK.
4. start ignored while busy. Pulse start again mid-line 2.
   - Frame length unchanged (18 beats); single frame_done; no second frame.
5. Asynchronous reset mid-frame. Assert reset between clock edges in line 1.
   - All outputs 0 immediately, without a clock edge.
   - After release, no activity until a new start; the new frame begins at col 0, line 0 with stall_count=0.
6. Default parameters. 398/2/336 with continuous pix_valid.
   - Exactly 134400 validout beats.
   - blanking_out=1 on beats where (n mod 400) ∈ {398, 399} (n counted from 0).
   - One frame_done.
